// File: rtl/mem_pkg.sv
// Purpose: shared definitions for the parametrised memory blocks (state encoding, read-during-write policies, default geometry).
// Latency: none; declarations only.
// Backpressure: not applicable.
package mem_pkg;

    // Clear-engine state encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Same-address read/write policy selectors.
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_READ_FIRST  = 0;

    // Default geometry reused by the memory blocks built on this package.
    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 6;

endpackage

// File: rtl/ram_clear_fsm.sv
// Purpose: clear engine that sweeps every memory address once after reset or on a clear request.
// Latency: a sweep takes exactly 2**ADDR_W edges; busy is combinational from the state register.
// Backpressure: while busy the owner must ignore all load/read/clear requests.
module ram_clear_fsm
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // State and sweep pointer; reset always restarts a full sweep from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state: terminal compare comes before the increment so ptr never wraps.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy       = (state_q == ST_CLEAR);
    // Reset itself never writes the array, so the sweep write is suppressed on a reset edge.
    assign sweep_we   = busy && !reset;
    assign sweep_addr = ptr_q;

endmodule

// File: rtl/ram_param.sv
// Purpose: parametrised single-clock RAM with separate write/read ports, selectable read-during-write policy and a clear sweep.
// Latency: read data and out_valid appear one edge after rd_en is accepted.
// Backpressure: while busy (clear sweep) load, rd_en and clear are dropped; clear in IDLE drops same-cycle requests.
module ram_param
    import mem_pkg::*;
#(
    parameter int                DATA_W    = DEFAULT_DATA_W,
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
    parameter int                RDW_MODE  = RDW_WRITE_FIRST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              svc;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_dat;
    logic              same_addr;

    ram_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // Normal service only in IDLE with no reset and no clear taking priority.
    assign svc       = !busy && !clear && !reset;
    assign arr_we    = sweep_we || (svc && load);
    assign arr_addr  = sweep_we ? sweep_addr : wr_addr;
    assign arr_dat   = sweep_we ? CLEAR_VAL : in;
    assign same_addr = load && (wr_addr == rd_addr);

    // Single write port shared by the sweep and user writes.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_dat;
        end
    end

    // Registered read; write-first forwards the incoming data, read-first sees the pre-write word.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (svc && rd_en) begin
            out_valid <= 1'b1;
            if (RDW_MODE == RDW_WRITE_FIRST && same_addr) begin
                out <= in;
            end else begin
                out <= mem[rd_addr];
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_param.sv
// Purpose: directed bench for ram_param, write-first and read-first builds driven side by side.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: busy-wait loops are bounded; an expired bound shows up as a wrong cycle count.
module tb_ram_param;

    logic        clk = 1'b0;
    logic        reset, clear, load, rd_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] in;
    logic [15:0] out_wf, out_rf;
    logic        vld_wf, vld_rf, busy_wf, busy_rf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_param #(.DATA_W(16), .ADDR_W(4), .CLEAR_VAL(16'hA5A5), .RDW_MODE(1)) u_wf (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .wr_addr(wr_addr), .in(in),
        .rd_en(rd_en), .rd_addr(rd_addr), .out(out_wf), .out_valid(vld_wf), .busy(busy_wf)
    );

    ram_param #(.DATA_W(16), .ADDR_W(4), .CLEAR_VAL(16'hA5A5), .RDW_MODE(0)) u_rf (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .wr_addr(wr_addr), .in(in),
        .rd_en(rd_en), .rd_addr(rd_addr), .out(out_rf), .out_valid(vld_rf), .busy(busy_rf)
    );

    typedef struct {
        logic        ld;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic        ev;
        logic [15:0] ewf;
        logic [15:0] erf;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic ld, logic [3:0] wa, logic [15:0] wd, logic re,
                                logic [3:0] ra, logic ev, logic [15:0] ewf, logic [15:0] erf);
        vec_t v;
        v.ld = ld; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.ev = ev; v.ewf = ewf; v.erf = erf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clear = 0; load = 0; rd_en = 0; wr_addr = '0; rd_addr = '0; in = '0;
    endtask

    // Steps until both copies leave the sweep; returns edges taken (bounded).
    task automatic count_busy(output int cnt);
        cnt = 0;
        while ((busy_wf || busy_rf) && cnt < 100) begin
            step();
            cnt++;
            if (vld_wf || vld_rf) chk("valid_during_sweep", {vld_wf, vld_rf}, 0);
        end
    endtask

    task automatic read_one(input string name, input logic [3:0] a, input logic [15:0] exp);
        idle_inputs();
        rd_en = 1; rd_addr = a;
        step();
        rd_en = 0;
        chk({name, "_vld"}, {vld_wf, vld_rf}, 2'b11);
        chk({name, "_wf"}, out_wf, exp);
        chk({name, "_rf"}, out_rf, exp);
    endtask

    initial begin
        int cnt;

        for (int i = 0; i < 16; i++)
            vecs[i] = mk(0, 0, 0, 1, 4'(i), 1, 16'hA5A5, 16'hA5A5);
        vecs[16] = mk(1, 3, 16'h1234, 1, 0, 1, 16'hA5A5, 16'hA5A5);
        vecs[17] = mk(0, 0, 16'h0000, 1, 3, 1, 16'h1234, 16'h1234);
        vecs[18] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h1234, 16'h1234);
        vecs[19] = mk(1, 5, 16'h0001, 0, 0, 0, 16'h1234, 16'h1234);
        vecs[20] = mk(1, 5, 16'h00FF, 1, 5, 1, 16'h00FF, 16'h0001);
        vecs[21] = mk(0, 0, 16'h0000, 1, 5, 1, 16'h00FF, 16'h00FF);
        vecs[22] = mk(1, 6, 16'h6666, 1, 3, 1, 16'h1234, 16'h1234);
        vecs[23] = mk(0, 0, 16'h0000, 1, 6, 1, 16'h6666, 16'h6666);

        // Reset state and first sweep length.
        idle_inputs();
        reset = 1;
        @(negedge clk);
        step();
        chk("rst_busy", {busy_wf, busy_rf}, 2'b11);
        chk("rst_vld", {vld_wf, vld_rf}, 2'b00);
        chk("rst_out_wf", out_wf, 16'h0000);
        chk("rst_out_rf", out_rf, 16'h0000);
        reset = 0;
        count_busy(cnt);
        chk("rst_sweep_len", cnt, 16);

        // Table: cleared contents, latency, hold, read-during-write, independent ports.
        for (int i = 0; i < NVEC; i++) begin
            load = vecs[i].ld; wr_addr = vecs[i].wa; in = vecs[i].wd;
            rd_en = vecs[i].re; rd_addr = vecs[i].ra; clear = 0;
            step();
            chk($sformatf("vec%0d_vld_wf", i), vld_wf, vecs[i].ev);
            chk($sformatf("vec%0d_vld_rf", i), vld_rf, vecs[i].ev);
            chk($sformatf("vec%0d_out_wf", i), out_wf, vecs[i].ewf);
            chk($sformatf("vec%0d_out_rf", i), out_rf, vecs[i].erf);
            chk($sformatf("vec%0d_busy", i), {busy_wf, busy_rf}, 2'b00);
        end

        // Clear beats a same-cycle write and read.
        idle_inputs();
        clear = 1; load = 1; wr_addr = 7; in = 16'hBEEF; rd_en = 1; rd_addr = 3;
        step();
        idle_inputs();
        chk("clr_pri_vld", {vld_wf, vld_rf}, 2'b00);
        chk("clr_pri_busy", {busy_wf, busy_rf}, 2'b11);
        chk("clr_pri_hold", out_wf, 16'h6666);
        count_busy(cnt);
        chk("clr_pri_len", cnt, 16);
        read_one("clr_pri_m7", 7, 16'hA5A5);
        read_one("clr_pri_m3", 3, 16'hA5A5);

        // Requests during a sweep are ignored.
        idle_inputs();
        clear = 1;
        step();
        idle_inputs();
        load = 1; wr_addr = 2; in = 16'h2222; rd_en = 1; rd_addr = 2;
        count_busy(cnt);
        chk("sweep_req_len", cnt, 16);
        read_one("sweep_req_m2", 2, 16'hA5A5);

        // Reset mid-sweep restarts a full sweep.
        idle_inputs();
        wr_addr = 9; in = 16'h9999; load = 1;
        step();
        idle_inputs();
        clear = 1;
        step();
        clear = 0;
        for (int i = 0; i < 8; i++) step();
        chk("mid_rst_busy_pre", {busy_wf, busy_rf}, 2'b11);
        reset = 1;
        step();
        reset = 0;
        chk("mid_rst_busy", {busy_wf, busy_rf}, 2'b11);
        count_busy(cnt);
        chk("mid_rst_len", cnt, 16);
        read_one("mid_rst_m9", 9, 16'hA5A5);

        // Clear held high: back-to-back sweeps with a single idle cycle between.
        idle_inputs();
        clear = 1;
        step();
        count_busy(cnt);
        chk("hold_clr_len1", cnt, 16);
        chk("hold_clr_gap", {busy_wf, busy_rf}, 2'b00);
        step();
        chk("hold_clr_restart", {busy_wf, busy_rf}, 2'b11);
        clear = 0;
        count_busy(cnt);
        chk("hold_clr_len2", cnt, 16);
        read_one("hold_clr_m15", 15, 16'hA5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
